// File: rtl/cpu_bmu_pkg.sv
// Shared definitions for the iterative bit-manipulation unit: op codes,
// FSM state encodings, shifter commands and the iteration-count helper.
package cpu_bmu_pkg;

   localparam int unsigned OP_W   = 6;
   localparam int unsigned ST_W   = 2;
   localparam int unsigned SHOP_W = 3;

   // Op codes, same encoding as the combinational BMU
   localparam logic [OP_W-1:0] BMU_CLZ  = 6'h01;
   localparam logic [OP_W-1:0] BMU_CTZ  = 6'h02;
   localparam logic [OP_W-1:0] BMU_CPOP = 6'h03;
   localparam logic [OP_W-1:0] BMU_ROL  = 6'h04;
   localparam logic [OP_W-1:0] BMU_ROR  = 6'h05;
   localparam logic [OP_W-1:0] BMU_ANDN = 6'h06;
   localparam logic [OP_W-1:0] BMU_ORN  = 6'h07;

   // FSM state encodings
   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
   localparam logic [ST_W-1:0] ST_DONE = 2'd2;

   // Working-register commands
   localparam logic [SHOP_W-1:0] SH_HOLD = 3'd0;
   localparam logic [SHOP_W-1:0] SH_LOAD = 3'd1;
   localparam logic [SHOP_W-1:0] SH_SHL  = 3'd2;
   localparam logic [SHOP_W-1:0] SH_SHR  = 3'd3;
   localparam logic [SHOP_W-1:0] SH_ROL  = 3'd4;
   localparam logic [SHOP_W-1:0] SH_ROR  = 3'd5;

   // Number of single-bit iterations an op needs (always >= 1).
   // Operands are zero-extended to 64 bits; xlen selects the active width.
   function automatic logic [7:0] iter_count(input logic [OP_W-1:0] op,
                                             input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int unsigned xlen);
      int unsigned n;
      int unsigned k;
      logic        found;
      logic [63:0] sh;
      n     = 1;
      k     = 0;
      found = 1'b0;
      sh    = '0;
      case (op)
         BMU_CLZ: begin
            for (int unsigned j = 0; j < 64; j++) begin
               if (j < xlen && !found) begin
                  if (a[6'(xlen - 1 - j)]) found = 1'b1;
                  else                     k = k + 1;
               end
            end
            n = (k + 1 < xlen) ? k + 1 : xlen;
         end
         BMU_CTZ: begin
            for (int unsigned j = 0; j < 64; j++) begin
               if (j < xlen && !found) begin
                  if (a[6'(j)]) found = 1'b1;
                  else          k = k + 1;
               end
            end
            n = (k + 1 < xlen) ? k + 1 : xlen;
         end
         BMU_CPOP: begin
            for (int unsigned j = 0; j < 64; j++) begin
               if (j < xlen && a[6'(j)]) n = j + 1;
            end
         end
         BMU_ROL, BMU_ROR: begin
            sh = b & 64'(xlen - 1);
            n  = (sh == 64'd0) ? 1 : 32'(sh);
         end
         default: n = 1;
      endcase
      return 8'(n);
   endfunction

endpackage

// File: rtl/cpu_bmu_iter_if.sv
// Request/response channel between issue logic and the iterative BMU.
interface cpu_bmu_iter_if #(
   parameter int unsigned XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [5:0]      req_control;
   logic [XLEN-1:0] req_a;
   logic [XLEN-1:0] req_b;
   logic            resp_valid;
   logic            resp_ready;
   logic [XLEN-1:0] resp_result;
   logic            resp_error;

   modport master (
      output req_valid, req_control, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_error
   );

   modport slave (
      input  req_valid, req_control, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_result, resp_error
   );
endinterface

// File: rtl/cpu_bmu_iter_shifter.sv
// Working register of the iterative BMU: load, single-bit shifts/rotates,
// with MSB/LSB taps of the current value.
module cpu_bmu_iter_shifter
   import cpu_bmu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SHOP_W-1:0] op,
   input  logic [XLEN-1:0]   din,
   output logic [XLEN-1:0]   q,
   output logic [XLEN-1:0]   nxt_c,
   output logic              tap_msb,
   output logic              tap_lsb
);

   // Next working value for the requested command
   always_comb begin
      nxt_c = q;
      case (op)
         SH_LOAD: nxt_c = din;
         SH_SHL:  nxt_c = {q[XLEN-2:0], 1'b0};
         SH_SHR:  nxt_c = {1'b0, q[XLEN-1:1]};
         SH_ROL:  nxt_c = {q[XLEN-2:0], q[XLEN-1]};
         SH_ROR:  nxt_c = {q[0], q[XLEN-1:1]};
         default: nxt_c = q;
      endcase
   end

   // Working register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= nxt_c;
   end

   assign tap_msb = q[XLEN-1];
   assign tap_lsb = q[0];

endmodule

// File: rtl/cpu_bmu_iter.sv
// Iterative bit-manipulation unit: CLZ/CTZ/CPOP/ROL/ROR/ANDN/ORN computed
// one bit per cycle behind valid/ready request and response channels.
// Optional busy-cycle statistics counter: define CPU_BMU_ITER_STATS_EN.
module cpu_bmu_iter
   import cpu_bmu_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   cpu_bmu_iter_if.slave      bus
`ifdef CPU_BMU_ITER_STATS_EN
   ,
   output logic [31:0]        stat_busy_cycles
`endif
);

   localparam int unsigned SH_W = $clog2(XLEN);

   logic [ST_W-1:0]   state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W-1:0]  acc, acc_nxt, acc_step;
   logic [OP_W-1:0]   op_q, op_nxt;
   logic [XLEN-1:0]   b_q, b_nxt;
   logic              rot_q, rot_nxt;
   logic              req_ready_q, req_ready_nxt;
   logic              resp_valid_q, resp_valid_nxt;
   logic [XLEN-1:0]   resp_result_q, resp_result_nxt;
   logic              resp_error_q, resp_error_nxt;
   logic              inc;

   logic [SHOP_W-1:0] sh_op;
   logic [XLEN-1:0]   sh_q, sh_nxt;
   logic              tap_msb, tap_lsb;

   cpu_bmu_iter_shifter #(.XLEN(XLEN)) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .op      (sh_op),
      .din     (bus.req_a),
      .q       (sh_q),
      .nxt_c   (sh_nxt),
      .tap_msb (tap_msb),
      .tap_lsb (tap_lsb)
   );

   // Working-register command: load on accept, one step per busy cycle
   always_comb begin
      sh_op = SH_HOLD;
      case (state)
         ST_IDLE: if (bus.req_valid && !flush) sh_op = SH_LOAD;
         ST_BUSY: begin
            if (!flush) begin
               case (op_q)
                  BMU_CLZ:           sh_op = SH_SHL;
                  BMU_CTZ, BMU_CPOP: sh_op = SH_SHR;
                  BMU_ROL:           sh_op = rot_q ? SH_ROL : SH_HOLD;
                  BMU_ROR:           sh_op = rot_q ? SH_ROR : SH_HOLD;
                  default:           sh_op = SH_HOLD;
               endcase
            end
         end
         default: sh_op = SH_HOLD;
      endcase
   end

   // Next state, counters and registered outputs
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      acc_nxt         = acc;
      op_nxt          = op_q;
      b_nxt           = b_q;
      rot_nxt         = rot_q;
      req_ready_nxt   = req_ready_q;
      resp_valid_nxt  = resp_valid_q;
      resp_result_nxt = resp_result_q;
      resp_error_nxt  = resp_error_q;
      inc             = 1'b0;
      acc_step        = acc;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid && !flush) begin
               op_nxt        = bus.req_control;
               b_nxt         = bus.req_b;
               rot_nxt       = |bus.req_b[SH_W-1:0];
               cnt_nxt       = CNT_W'(iter_count(bus.req_control, 64'(bus.req_a),
                                                 64'(bus.req_b), XLEN));
               acc_nxt       = '0;
               req_ready_nxt = 1'b0;
               state_nxt     = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (flush) begin
               cnt_nxt       = '0;
               req_ready_nxt = 1'b1;
               state_nxt     = ST_IDLE;
            end else begin
               case (op_q)
                  BMU_CLZ:  inc = ~tap_msb;
                  BMU_CTZ:  inc = ~tap_lsb;
                  BMU_CPOP: inc = tap_lsb;
                  default:  inc = 1'b0;
               endcase
               acc_step = acc + CNT_W'(inc);
               acc_nxt  = acc_step;
               cnt_nxt  = cnt - CNT_W'(1);
               // Final iteration: capture the result into the response registers
               if (cnt <= CNT_W'(1)) begin
                  state_nxt      = ST_DONE;
                  resp_valid_nxt = 1'b1;
                  resp_error_nxt = 1'b0;
                  case (op_q)
                     BMU_CLZ, BMU_CTZ, BMU_CPOP: resp_result_nxt = XLEN'(acc_step);
                     BMU_ROL, BMU_ROR:           resp_result_nxt = sh_nxt;
                     BMU_ANDN:                   resp_result_nxt = sh_q & ~b_q;
                     BMU_ORN:                    resp_result_nxt = sh_q | ~b_q;
                     default: begin
                        resp_result_nxt = '0;
                        resp_error_nxt  = 1'b1;
                     end
                  endcase
               end
            end
         end
         ST_DONE: begin
            if (flush || bus.resp_ready) begin
               resp_valid_nxt = 1'b0;
               req_ready_nxt  = 1'b1;
               state_nxt      = ST_IDLE;
            end
         end
         default: begin
            resp_valid_nxt = 1'b0;
            req_ready_nxt  = 1'b1;
            state_nxt      = ST_IDLE;
         end
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         acc           <= '0;
         op_q          <= '0;
         b_q           <= '0;
         rot_q         <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_result_q <= '0;
         resp_error_q  <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         acc           <= acc_nxt;
         op_q          <= op_nxt;
         b_q           <= b_nxt;
         rot_q         <= rot_nxt;
         req_ready_q   <= req_ready_nxt;
         resp_valid_q  <= resp_valid_nxt;
         resp_result_q <= resp_result_nxt;
         resp_error_q  <= resp_error_nxt;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_error  = resp_error_q;

`ifdef CPU_BMU_ITER_STATS_EN
   // Saturating count of cycles spent in BUSY; cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        stat_busy_cycles <= '0;
      else if (state == ST_BUSY && stat_busy_cycles != '1) stat_busy_cycles <= stat_busy_cycles + 32'd1;
   end
`endif

endmodule

// File: tb/tb_cpu_bmu_iter.sv
// Directed self-checking bench for cpu_bmu_iter (XLEN = 32).
module tb_cpu_bmu_iter;
   import cpu_bmu_pkg::*;

   localparam int unsigned XLEN = 32;

   typedef struct {
      logic [5:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
      int          lat;
   } vec_t;

   logic clk;
   logic rst_n;
   logic flush;
   int   tests;
   int   fails;
   vec_t vecs[17];

   cpu_bmu_iter_if #(.XLEN(XLEN)) bif ();

`ifdef CPU_BMU_ITER_STATS_EN
   logic [31:0] stat_busy_cycles;
   cpu_bmu_iter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bif),
      .stat_busy_cycles(stat_busy_cycles)
   );
`else
   cpu_bmu_iter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bif)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Issue one op (called just after a rising edge) and wait for its response.
   task automatic issue(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      int n;
      n = 0;
      while (!bif.req_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      bif.req_control = ctrl;
      bif.req_a       = a;
      bif.req_b       = b;
      bif.req_valid   = 1'b1;
      @(posedge clk); #1;
      bif.req_valid   = 1'b0;
      lat = 0;
      while (!bif.resp_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      issue(v.ctrl, v.a, v.b, lat);
      check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
      check($sformatf("v%0d result", idx), 64'(bif.resp_result), 64'(v.res));
      check($sformatf("v%0d error", idx), 64'(bif.resp_error), 64'(v.err));
      @(posedge clk); #1;
      check($sformatf("v%0d idle after handshake", idx),
            64'({bif.resp_valid, bif.req_ready}), 64'(2'b01));
   endtask

   initial begin
      int lat;
      logic seen;
      tests = 0;
      fails = 0;

      vecs[0]  = '{BMU_CLZ,  32'h0000_0006, 32'h0,         32'd29,        1'b0, 30};
      vecs[1]  = '{BMU_CLZ,  32'h0000_0000, 32'h0,         32'd32,        1'b0, 32};
      vecs[2]  = '{BMU_CPOP, 32'hF0F0_F0F0, 32'h0,         32'd16,        1'b0, 32};
      vecs[3]  = '{BMU_CTZ,  32'h0F00_0020, 32'h0,         32'd5,         1'b0, 6};
      vecs[4]  = '{BMU_ROL,  32'h8000_0000, 32'h1,         32'h0000_0001, 1'b0, 1};
      vecs[5]  = '{BMU_ROR,  32'h0000_0001, 32'h4,         32'h1000_0000, 1'b0, 4};
      vecs[6]  = '{BMU_ROR,  32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0, 1};
      vecs[7]  = '{BMU_ROR,  32'h0000_00F0, 32'd36,        32'h0000_000F, 1'b0, 4};
      vecs[8]  = '{BMU_ANDN, 32'hF0F0_FFFF, 32'h0F0F_F0F0, 32'hF0F0_0F0F, 1'b0, 1};
      vecs[9]  = '{BMU_ORN,  32'h0000_0000, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 1};
      vecs[10] = '{6'h3F,    32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         1'b1, 1};
      vecs[11] = '{BMU_CTZ,  32'h0000_0000, 32'h0,         32'd32,        1'b0, 32};
      vecs[12] = '{BMU_CPOP, 32'h0000_0001, 32'h0,         32'd1,         1'b0, 1};
      vecs[13] = '{BMU_CPOP, 32'h0000_0000, 32'h0,         32'd0,         1'b0, 1};
      vecs[14] = '{BMU_CLZ,  32'h8000_0000, 32'h0,         32'd0,         1'b0, 1};
      vecs[15] = '{BMU_ROL,  32'h1234_5678, 32'h8,         32'h3456_7812, 1'b0, 8};
      vecs[16] = '{BMU_CTZ,  32'h8000_0000, 32'h0,         32'd31,        1'b0, 32};

      rst_n           = 1'b0;
      flush           = 1'b0;
      bif.req_valid   = 1'b0;
      bif.req_control = '0;
      bif.req_a       = '0;
      bif.req_b       = '0;
      bif.resp_ready  = 1'b1;

      #12;
      check("reset req_ready", 64'(bif.req_ready), 64'd1);
      check("reset resp_valid", 64'(bif.resp_valid), 64'd0);
      check("reset resp_result", 64'(bif.resp_result), 64'd0);
      check("reset resp_error", 64'(bif.resp_error), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

      // Backpressure: hold the response, a second request waits for IDLE
      bif.resp_ready = 1'b0;
      issue(BMU_CLZ, 32'h0001_0000, 32'h0, lat);
      check("bp latency", 64'(lat), 64'd16);
      bif.req_control = BMU_CTZ;
      bif.req_a       = 32'h0000_0008;
      bif.req_b       = 32'h0;
      bif.req_valid   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp hold %0d", i),
               64'({bif.resp_valid, bif.req_ready, bif.resp_result}),
               64'({1'b1, 1'b0, 32'd15}));
      end
      bif.resp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp handshake idle", 64'({bif.resp_valid, bif.req_ready}), 64'(2'b01));
      @(posedge clk); #1;
      check("bp second accepted", 64'(bif.req_ready), 64'd0);
      bif.req_valid = 1'b0;
      lat = 0;
      while (!bif.resp_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      check("bp second latency", 64'(lat), 64'd4);
      check("bp second result", 64'(bif.resp_result), 64'd3);
      @(posedge clk); #1;

      // Flush a long CLZ mid-way; no response may follow
      bif.req_control = BMU_CLZ;
      bif.req_a       = 32'h0;
      bif.req_valid   = 1'b1;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush idle", 64'({bif.resp_valid, bif.req_ready}), 64'(2'b01));
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bif.resp_valid) seen = 1'b1;
      end
      check("flush no response", 64'(seen), 64'd0);
      run_vec(vecs[0], 100);

      // Asynchronous reset mid-BUSY clears outputs immediately
      bif.req_control = BMU_CPOP;
      bif.req_a       = 32'hFFFF_FFFF;
      bif.req_valid   = 1'b1;
      @(posedge clk); #1;
      bif.req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset outputs",
            64'({bif.req_ready, bif.resp_valid, bif.resp_error, bif.resp_result}),
            64'({1'b1, 1'b0, 1'b0, 32'd0}));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(vecs[0], 200);
`ifdef CPU_BMU_ITER_STATS_EN
      check("stat busy cycles", 64'(stat_busy_cycles), 64'd30);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
